// File: rtl/ad_rx.sv
// ============================================================================
// ad_rx -- serial capture front-end for the external 24-bit sigma-delta ADC.
//
// Waits for a falling edge on the ADC data-ready line, then runs one frame on
// the 3-wire link: chip select low, a setup gap of SCLK_DIV cycles, DATA_W
// sclk periods (SCLK_DIV high + SCLK_DIV low each), one DONE cycle. The sample
// is shifted in MSB first and presented on real_data with a one-cycle
// real_vld. Data-ready edges that arrive while a frame is in flight are
// dropped and counted in stat_ad_miss.
//
// Frame timing, with E the first cycle in which ad_cs_n is low:
//   E .. E+SCLK_DIV-1              setup, sclk low
//   E+SCLK_DIV .. E+49*SCLK_DIV-1  24 sclk periods
//   E+49*SCLK_DIV                  DONE: ad_cs_n high, real_vld high
//
// Ports:
//   clk_sys       in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   ad_drdy_n     in   ADC data ready, falling edge = new sample (async)
//   ad_dout       in   ADC serial data, MSB first, changes on sclk fall (async)
//   ad_cs_n       out  ADC chip select, active low
//   ad_sclk       out  ADC serial clock, idles low
//   real_data     out  captured sample, two's complement, unmodified
//   real_vld      out  one-cycle strobe qualifying real_data
//   cfg_ad_en     in   capture enable, any nonzero value enables
//   stat_ad_miss  out  data-ready edges dropped while busy, saturating
//
// Parameters:
//   SCLK_DIV  clk_sys cycles per sclk half-period, 3..255. The lower bound
//             leaves room for the 2-flop dout synchronizer between an sclk
//             fall and the next capture point.
//   DATA_W    sample width, equal to the sclk periods per frame.
// ============================================================================
module ad_rx #(
   parameter int SCLK_DIV = 4,
   parameter int DATA_W   = 24
) (
   input  logic              clk_sys,
   input  logic              rst_n,
   input  logic              ad_drdy_n,
   input  logic              ad_dout,
   output logic              ad_cs_n,
   output logic              ad_sclk,
   output logic [DATA_W-1:0] real_data,
   output logic              real_vld,
   input  logic [7:0]        cfg_ad_en,
   output logic [7:0]        stat_ad_miss
);

   // -------------------------------------------------------------------------
   // Local constants
   // -------------------------------------------------------------------------
   localparam int HC_W = 8;                                   // holds up to 255
   localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [HC_W-1:0] HALF_LAST = HC_W'(SCLK_DIV - 1);
   localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(DATA_W - 1);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_CS_SETUP = 2'd1;
   localparam logic [1:0] ST_SHIFT    = 2'd2;
   localparam logic [1:0] ST_DONE     = 2'd3;

   // -------------------------------------------------------------------------
   // Signals
   // -------------------------------------------------------------------------
   logic              drdy_meta;
   logic              drdy_sync;
   logic              drdy_prev;
   logic              dout_meta;
   logic              dout_sync;
   logic              drdy_fall;
   logic              capture_en;

   logic [1:0]        state;
   logic [HC_W-1:0]   half_cnt;
   logic [BC_W-1:0]   bit_cnt;
   logic [DATA_W-1:0] shift_reg;

   // -------------------------------------------------------------------------
   // Input synchronizers and data-ready edge detect
   // -------------------------------------------------------------------------
   // drdy flops reset high so that reset release never looks like a fall.
   // NOTE: every clocked assignment is non-blocking so each flop samples the
   // value its neighbour held before the edge; blocking here would collapse
   // the two-flop chain into a single stage.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         drdy_meta <= 1'b1;
         drdy_sync <= 1'b1;
         drdy_prev <= 1'b1;
         dout_meta <= 1'b0;
         dout_sync <= 1'b0;
      end else begin
         drdy_meta <= ad_drdy_n;
         drdy_sync <= drdy_meta;
         drdy_prev <= drdy_sync;
         dout_meta <= ad_dout;
         dout_sync <= dout_meta;
      end
   end

   // Both operands are flops, so this is a clean single-cycle event.
   assign drdy_fall  = drdy_prev & ~drdy_sync;
   assign capture_en = |cfg_ad_en;

   // -------------------------------------------------------------------------
   // Frame sequencer
   // -------------------------------------------------------------------------
   // ad_cs_n and ad_sclk are updated on the same edge as the state change, so
   // each registered pin level matches the state of the cycle it appears in.
   // ad_sclk doubles as the phase flag inside SHIFT (1 = high half-period).
   // NOTE: the shift register is reset along with the control state even
   // though real_data only ever copies a fully shifted word; it is narrow and
   // keeping it deterministic avoids X in simulation after reset.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         half_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         ad_cs_n   <= 1'b1;
         ad_sclk   <= 1'b0;
         real_data <= '0;
         real_vld  <= 1'b0;
      end else begin
         real_vld <= 1'b0;

         case (state)
            ST_IDLE: begin
               ad_cs_n  <= 1'b1;
               ad_sclk  <= 1'b0;
               half_cnt <= '0;
               if (drdy_fall && capture_en) begin
                  state   <= ST_CS_SETUP;
                  ad_cs_n <= 1'b0;
               end
            end

            ST_CS_SETUP: begin
               if (half_cnt == HALF_LAST) begin
                  state    <= ST_SHIFT;
                  half_cnt <= '0;
                  bit_cnt  <= '0;
                  ad_sclk  <= 1'b1;
               end else begin
                  half_cnt <= half_cnt + HC_W'(1);
               end
            end

            ST_SHIFT: begin
               if (half_cnt != HALF_LAST) begin
                  half_cnt <= half_cnt + HC_W'(1);
               end else begin
                  half_cnt <= '0;
                  if (ad_sclk) begin
                     // Last high cycle: the ADC has held this bit since the
                     // previous sclk fall, well past the synchronizer delay.
                     shift_reg <= {shift_reg[DATA_W-2:0], dout_sync};
                     ad_sclk   <= 1'b0;
                  end else if (bit_cnt == BIT_LAST) begin
                     state     <= ST_DONE;
                     ad_cs_n   <= 1'b1;
                     real_data <= shift_reg;
                     real_vld  <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + BC_W'(1);
                     ad_sclk <= 1'b1;
                  end
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state   <= ST_IDLE;
               ad_cs_n <= 1'b1;
               ad_sclk <= 1'b0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Missed data-ready counter
   // -------------------------------------------------------------------------
   // Any fall outside IDLE is a drop, including the DONE cycle, regardless of
   // the enable setting. Saturates rather than wraps.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         stat_ad_miss <= 8'h00;
      end else if (drdy_fall && (state != ST_IDLE) && (stat_ad_miss != 8'hFF)) begin
         stat_ad_miss <= stat_ad_miss + 8'd1;
      end
   end

endmodule

// File: tb/tb_ad_rx.sv
// ============================================================================
// tb_ad_rx -- self-checking bench for ad_rx.
//
// u_dut  (SCLK_DIV=4) is compared every cycle against a frame-timeline model:
// a detected data-ready fall either starts a frame (IDLE, enabled) or counts a
// miss, and the expected pin levels follow from the cycle offset inside the
// frame. u_dut3 (SCLK_DIV=3) gets a directed latency/data check.
// ============================================================================
`timescale 1ns/1ps
module tb_ad_rx;

   localparam int D     = 4;
   localparam int D3    = 3;
   localparam int W     = 24;
   localparam int FRAME = 49 * D;      // offset of the DONE cycle from E

   // -------------------------------------------------------------------------
   // Clock, reset, DUT signals
   // -------------------------------------------------------------------------
   logic          clk_sys = 1'b0;
   logic          rst_n   = 1'b1;
   always #5 clk_sys = ~clk_sys;

   logic          ad_drdy_n = 1'b1;
   logic          ad_dout   = 1'b0;
   logic [7:0]    cfg_ad_en = 8'h00;
   logic          ad_cs_n;
   logic          ad_sclk;
   logic [W-1:0]  real_data;
   logic          real_vld;
   logic [7:0]    stat_ad_miss;

   logic          ad_drdy3_n = 1'b1;
   logic          ad_dout3   = 1'b0;
   logic [7:0]    cfg_ad_en3 = 8'h00;
   logic          ad_cs3_n;
   logic          ad_sclk3;
   logic [W-1:0]  real_data3;
   logic          real_vld3;
   logic [7:0]    stat_ad_miss3;

   ad_rx #(.SCLK_DIV(D), .DATA_W(W)) u_dut (
      .clk_sys      (clk_sys),
      .rst_n        (rst_n),
      .ad_drdy_n    (ad_drdy_n),
      .ad_dout      (ad_dout),
      .ad_cs_n      (ad_cs_n),
      .ad_sclk      (ad_sclk),
      .real_data    (real_data),
      .real_vld     (real_vld),
      .cfg_ad_en    (cfg_ad_en),
      .stat_ad_miss (stat_ad_miss)
   );

   ad_rx #(.SCLK_DIV(D3), .DATA_W(W)) u_dut3 (
      .clk_sys      (clk_sys),
      .rst_n        (rst_n),
      .ad_drdy_n    (ad_drdy3_n),
      .ad_dout      (ad_dout3),
      .ad_cs_n      (ad_cs3_n),
      .ad_sclk      (ad_sclk3),
      .real_data    (real_data3),
      .real_vld     (real_vld3),
      .cfg_ad_en    (cfg_ad_en3),
      .stat_ad_miss (stat_ad_miss3)
   );

   // -------------------------------------------------------------------------
   // Check bookkeeping
   // -------------------------------------------------------------------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // -------------------------------------------------------------------------
   // ADC models: MSB presented when cs_n falls, next bit on each sclk fall
   // -------------------------------------------------------------------------
   logic [W-1:0] adc_word  = '0;
   logic [W-1:0] adc_word3 = '0;
   int           adc_idx   = 0;
   int           adc_idx3  = 0;
   logic         adc_cs_q  = 1'b1, adc_sclk_q  = 1'b0;
   logic         adc_cs3_q = 1'b1, adc_sclk3_q = 1'b0;

   always @(ad_cs_n or ad_sclk) begin
      if (adc_cs_q === 1'b1 && ad_cs_n === 1'b0) begin
         adc_idx = W - 1;
         ad_dout = adc_word[adc_idx];
      end else if (adc_sclk_q === 1'b1 && ad_sclk === 1'b0 && adc_idx > 0) begin
         adc_idx--;
         ad_dout = adc_word[adc_idx];
      end
      adc_cs_q   = ad_cs_n;
      adc_sclk_q = ad_sclk;
   end

   always @(ad_cs3_n or ad_sclk3) begin
      if (adc_cs3_q === 1'b1 && ad_cs3_n === 1'b0) begin
         adc_idx3 = W - 1;
         ad_dout3 = adc_word3[adc_idx3];
      end else if (adc_sclk3_q === 1'b1 && ad_sclk3 === 1'b0 && adc_idx3 > 0) begin
         adc_idx3--;
         ad_dout3 = adc_word3[adc_idx3];
      end
      adc_cs3_q   = ad_cs3_n;
      adc_sclk3_q = ad_sclk3;
   end

   // -------------------------------------------------------------------------
   // Behavioural model of u_dut
   // cyc is the index of the current cycle (edges seen so far). det_q holds
   // the cycles in which a driven drdy fall becomes visible after the 2-flop
   // synchronizer and edge detect. m_t is the offset from E (-1: no frame).
   // -------------------------------------------------------------------------
   int           cyc     = 0;
   int           det_q[$];
   int           m_t     = -1;
   int           m_miss  = 0;
   logic [W-1:0] m_word  = '0;
   logic [W-1:0] m_data  = '0;
   bit           m_start = 1'b0;

   always @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         m_t    = -1;
         m_miss = 0;
         m_data = '0;
         det_q.delete();
      end else begin
         m_start = 1'b0;
         if (det_q.size() > 0 && det_q[0] == cyc) begin
            void'(det_q.pop_front());
            if (m_t >= 0)
               m_miss = (m_miss < 255) ? m_miss + 1 : 255;
            else if (cfg_ad_en != 8'h00)
               m_start = 1'b1;
         end
         if (m_t >= 0)
            m_t = (m_t == FRAME) ? -1 : m_t + 1;
         if (m_start) begin
            m_t    = 0;
            m_word = adc_word;
         end
         if (m_t == FRAME)
            m_data = m_word;
         cyc++;
      end
   end

   function automatic logic exp_cs_n(input int t);
      return !(t >= 0 && t < FRAME);
   endfunction

   function automatic logic exp_sclk(input int t);
      return (t >= D) && (t < FRAME) && (((t - D) % (2 * D)) < D);
   endfunction

   // Per-cycle comparison, sampled away from the active edge
   bit chk_on = 1'b0;
   always @(negedge clk_sys) begin
      if (chk_on) begin
         check("cs_n",  {31'b0, ad_cs_n},  {31'b0, exp_cs_n(m_t)});
         check("sclk",  {31'b0, ad_sclk},  {31'b0, exp_sclk(m_t)});
         check("vld",   {31'b0, real_vld}, {31'b0, (m_t == FRAME)});
         check("data",  {8'b0, real_data}, {8'b0, m_data});
         check("miss",  {24'b0, stat_ad_miss}, m_miss[31:0]);
      end
   end

   // -------------------------------------------------------------------------
   // Frame monitors used by the literal checks
   // -------------------------------------------------------------------------
   int           mon_e = 0, mon_vld_cyc = 0, mon_cs_low = 0, mon_rises = 0;
   int           mon_vld_cnt = 0, mon_frames = 0;
   logic [W-1:0] mon_data = '0;
   logic         mon_cs_d = 1'b1, mon_sclk_d = 1'b0;

   always @(negedge clk_sys) begin
      if (mon_cs_d === 1'b1 && ad_cs_n === 1'b0) begin
         mon_e      = cyc;
         mon_cs_low = 0;
         mon_rises  = 0;
         mon_frames++;
      end
      if (ad_cs_n === 1'b0) mon_cs_low++;
      if (mon_sclk_d === 1'b0 && ad_sclk === 1'b1) mon_rises++;
      if (real_vld === 1'b1) begin
         mon_vld_cnt++;
         mon_vld_cyc = cyc;
         mon_data    = real_data;
      end
      mon_cs_d   = ad_cs_n;
      mon_sclk_d = ad_sclk;
   end

   int           mon3_e = 0, mon3_vld_cyc = 0, mon3_rises = 0, mon3_vld_cnt = 0;
   logic [W-1:0] mon3_data = '0;
   logic         mon3_cs_d = 1'b1, mon3_sclk_d = 1'b0;

   always @(negedge clk_sys) begin
      if (mon3_cs_d === 1'b1 && ad_cs3_n === 1'b0) begin
         mon3_e     = cyc;
         mon3_rises = 0;
      end
      if (mon3_sclk_d === 1'b0 && ad_sclk3 === 1'b1) mon3_rises++;
      if (real_vld3 === 1'b1) begin
         mon3_vld_cnt++;
         mon3_vld_cyc = cyc;
         mon3_data    = real_data3;
      end
      mon3_cs_d   = ad_cs3_n;
      mon3_sclk_d = ad_sclk3;
   end

   // -------------------------------------------------------------------------
   // Stimulus helpers
   // -------------------------------------------------------------------------
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   // drdy low for 2 cycles, high for 2; the fall is visible two cycles later
   task automatic drdy_pulse();
      ad_drdy_n = 1'b0;
      det_q.push_back(cyc + 2);
      tick(2);
      ad_drdy_n = 1'b1;
      tick(2);
   endtask

   task automatic wait_vld(input int base, input string name);
      int k = 0;
      while (mon_vld_cnt == base && k < 400) begin
         tick();
         k++;
      end
      check(name, {31'b0, (mon_vld_cnt > base)}, 32'd1);
   endtask

   task automatic wait_cyc(input int target);
      int k = 0;
      while (cyc < target && k < 400) begin
         tick();
         k++;
      end
   endtask

   // -------------------------------------------------------------------------
   // Directed sequence
   // -------------------------------------------------------------------------
   int base, frames0;

   initial begin
      #2 rst_n = 1'b0;
      chk_on = 1'b1;
      tick(3);
      check("rst_cs_n", {31'b0, ad_cs_n},  32'd1);
      check("rst_sclk", {31'b0, ad_sclk},  32'd0);
      check("rst_data", {8'b0, real_data}, 32'd0);
      check("rst_vld",  {31'b0, real_vld}, 32'd0);
      check("rst_miss", {24'b0, stat_ad_miss}, 32'd0);
      rst_n = 1'b1;
      tick(3);

      // Basic frame
      cfg_ad_en = 8'h01;
      adc_word  = 24'hA5A5A5;
      base = mon_vld_cnt;
      drdy_pulse();
      wait_vld(base, "basic_vld_timeout");
      tick(2);
      check("basic_data",    {8'b0, mon_data}, 32'h00A5A5A5);
      check("basic_latency", mon_vld_cyc - mon_e, 32'd196);
      check("basic_cs_low",  mon_cs_low, 32'd196);
      check("basic_rises",   mon_rises, 32'd24);

      // Sign and MSB order
      adc_word = 24'h800001;
      base = mon_vld_cnt;
      drdy_pulse();
      wait_vld(base, "sign1_vld_timeout");
      tick(2);
      check("sign1_data", {8'b0, mon_data}, 32'h00800001);
      adc_word = 24'h7FFFFE;
      drdy_pulse();
      wait_vld(base + 1, "sign2_vld_timeout");
      tick(2);
      check("sign2_data",  {8'b0, mon_data}, 32'h007FFFFE);
      check("sign_pulses", mon_vld_cnt - base, 32'd2);
      check("sign_miss",   {24'b0, stat_ad_miss}, 32'd0);

      // Disabled: drdy falls start nothing and count nothing
      cfg_ad_en = 8'h00;
      frames0 = mon_frames;
      base    = mon_vld_cnt;
      repeat (5) drdy_pulse();
      tick(5);
      check("dis_frames", mon_frames,  frames0);
      check("dis_vld",    mon_vld_cnt, base);
      check("dis_rises",  mon_rises,   32'd24);
      check("dis_miss",   {24'b0, stat_ad_miss}, 32'd0);

      // Enable cleared mid-frame: frame still completes
      cfg_ad_en = 8'h80;
      adc_word  = 24'h123456;
      base = mon_vld_cnt;
      drdy_pulse();
      wait_cyc(mon_e + 100);
      cfg_ad_en = 8'h00;
      wait_vld(base, "clr_vld_timeout");
      tick(2);
      check("clr_data", {8'b0, mon_data}, 32'h00123456);
      frames0 = mon_frames;
      drdy_pulse();
      tick(20);
      check("clr_no_restart", mon_frames, frames0);

      // Busy drdy 50 cycles after E
      cfg_ad_en = 8'h01;
      adc_word  = 24'hC3C3C3;
      frames0 = mon_frames;
      base    = mon_vld_cnt;
      drdy_pulse();
      wait_cyc(mon_e + 50);
      drdy_pulse();
      wait_vld(base, "busy_vld_timeout");
      tick(10);
      check("busy_data",   {8'b0, mon_data}, 32'h00C3C3C3);
      check("busy_frames", mon_frames - frames0, 32'd1);
      check("busy_miss",   {24'b0, stat_ad_miss}, 32'd1);

      // Saturation: a long train of edges, most of which land mid-frame
      repeat (400) drdy_pulse();
      tick(250);
      check("sat_miss", {24'b0, stat_ad_miss}, 32'h000000FF);
      check("sat_data", {8'b0, mon_data}, 32'h00C3C3C3);
      repeat (20) drdy_pulse();
      tick(250);
      check("sat_hold", {24'b0, stat_ad_miss}, 32'h000000FF);

      // Reset mid-frame at E+60 (sclk high at that offset)
      adc_word = 24'h0F0F0F;
      drdy_pulse();
      wait_cyc(mon_e + 60);
      check("pre_rst_sclk", {31'b0, ad_sclk}, 32'd1);
      base  = mon_vld_cnt;
      rst_n = 1'b0;
      #1;
      check("mid_rst_cs_n", {31'b0, ad_cs_n},  32'd1);
      check("mid_rst_sclk", {31'b0, ad_sclk},  32'd0);
      check("mid_rst_data", {8'b0, real_data}, 32'd0);
      check("mid_rst_vld",  {31'b0, real_vld}, 32'd0);
      check("mid_rst_miss", {24'b0, stat_ad_miss}, 32'd0);
      tick(5);
      rst_n = 1'b1;
      tick(200);
      check("post_rst_no_vld", mon_vld_cnt, base);
      drdy_pulse();
      wait_vld(base, "post_rst_vld_timeout");
      tick(2);
      check("post_rst_data", {8'b0, mon_data}, 32'h000F0F0F);

      // Minimum divider instance
      cfg_ad_en3 = 8'h01;
      adc_word3  = 24'h5A5A5A;
      ad_drdy3_n = 1'b0;
      tick(2);
      ad_drdy3_n = 1'b1;
      begin
         int k = 0;
         while (mon3_vld_cnt == 0 && k < 400) begin
            tick();
            k++;
         end
      end
      check("d3_vld_seen", mon3_vld_cnt, 32'd1);
      check("d3_latency",  mon3_vld_cyc - mon3_e, 32'd147);
      check("d3_data",     {8'b0, mon3_data}, 32'h005A5A5A);
      check("d3_rises",    mon3_rises, 32'd24);

      tick(5);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ad_rx.md
Name: ad_rx

Overview:
- Serial capture front-end for the external 24-bit sigma-delta ADC.
- Waits for the ADC data-ready strobe, then clocks out one 24-bit sample over a 3-wire SPI-style link (cs_n, sclk, dout).
- Presents the sample as real_data with a one-cycle real_vld.
- Sits directly upstream of the AD source mux and drives its real_data/real_vld inputs.

Parameters:
- SCLK_DIV, 4: clk_sys cycles per sclk half-period. Legal range 3..255; the minimum of 3 covers the 2-flop dout synchronizer.
- DATA_W, 24: sample width in bits. Equals the number of sclk periods per frame.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ad_drdy_n  in  1  ADC data-ready; falling edge means a new sample is available. Asynchronous to clk_sys.
- ad_dout  in  1  ADC serial data, MSB first. ADC updates it on sclk falling edge. Asynchronous.
- ad_cs_n  out  1  ADC chip select, active low.
- ad_sclk  out  1  ADC serial clock, idles low.
- real_data  out  24  captured sample, two's complement, passed unmodified.
- real_vld  out  1  one-cycle strobe; real_data is valid in that cycle.
- cfg_ad_en  in  8  capture enable; any nonzero value enables capture.
- stat_ad_miss  out  8  count of drdy edges dropped while busy; saturates at 8'hFF.

Behaviour:
- Reset values (asynchronous, rst_n low):
  - ad_cs_n=1, ad_sclk=0, real_data=0, real_vld=0, stat_ad_miss=0.
  - state=IDLE; synchronizer flops set to 1 (drdy) and 0 (dout).
- Input synchronization:
  - ad_drdy_n and ad_dout each pass through a 2-flop synchronizer.
  - A drdy fall is a registered edge detect: prev synced=1 and synced=0. It is a 1-cycle event.
- All outputs are registered; no combinational path from input to output.
- State IDLE:
  - cs_n=1, sclk=0.
  - drdy fall with cfg_ad_en!=0 -> CS_SETUP.
  - drdy fall with cfg_ad_en==0 -> stays in IDLE; no miss count.
- State CS_SETUP:
  - cs_n=0, sclk=0, lasts SCLK_DIV cycles, then -> SHIFT.
  - Let E = the first cycle in which cs_n is low.
- State SHIFT: 24 sclk periods.
  - Each period is SCLK_DIV cycles with sclk=1, then SCLK_DIV cycles with sclk=0.
  - On the last high cycle of each period, the synced dout is shifted in at the LSB of the shift register. The first bit captured is the MSB.
  - A bit counter (0..23) and a half-period counter (0..SCLK_DIV-1) control the sequence.
  - After the low phase of period 24 -> DONE.
- State DONE, 1 cycle:
  - cs_n=1, sclk=0, real_data <= shift register, real_vld=1, then -> IDLE.
- Latency:
  - real_vld is high in cycle E + 49*SCLK_DIV (E+196 at default).
  - Frame occupancy: 49*SCLK_DIV+1 cycles.
- real_data holds its value between frames. real_vld is low in every cycle except DONE.
- drdy fall in CS_SETUP, SHIFT or DONE:
  - Ignored; the frame in progress continues untouched.
  - stat_ad_miss increments by 1, saturating at 255 (no wrap).
- cfg_ad_en cleared mid-frame: the current frame completes and pulses real_vld; no new frame starts.
- drdy fall in the same cycle that DONE -> IDLE: counted as a miss, because the state is not IDLE.
- rst_n asserted mid-frame: all outputs go immediately to their reset values. No partial real_vld. After release, the block waits for a fresh drdy fall.
- stat_ad_miss is cleared only by reset.

Test Plan:
- Basic frame: SCLK_DIV=4, enable=8'h01, ADC model returns 24'hA5A5A5 -> ad_cs_n low for 49*4 cycles, exactly 24 sclk pulses each 4 high/4 low, real_vld one cycle at E+196, real_data=24'hA5A5A5.
- Sign and MSB order: model returns 24'h800001, then 24'h7FFFFE on the next drdy -> real_data=24'h800001, then 24'h7FFFFE. Two real_vld pulses, stat_ad_miss=0.
- Busy drdy: second drdy fall 50 cycles after E -> first frame completes with correct data, no extra frame, stat_ad_miss=1. Repeat 300 busy edges -> stat_ad_miss=8'hFF, holds there.
- Disable: cfg_ad_en=8'h00, 5 drdy falls -> ad_cs_n stays 1, no sclk, no real_vld, stat_ad_miss=0. Clear enable at E+100 -> the frame still completes with real_vld.
- Reset mid-frame: assert rst_n at E+60 -> ad_cs_n=1, ad_sclk=0, real_data=0 asynchronously, no real_vld. After release plus a new drdy, a normal frame returns the correct data.
- Minimum divider: SCLK_DIV=3, pattern 24'h5A5A5A with dout changing on sclk fall -> real_data=24'h5A5A5A, real_vld at E+147.
